battleship_turn_ctrl: RTL and testbench
=======================================

// Module: battleship_turn_ctrl
// PURPOSE
//  Parametrised N-player game controller for the battleship design; successor to the 2-state-input game FSM.
//  Sequences IDLE/SETUP/TURN/EVAL/GAME_OVER and rotates turns round-robin over NUM_PLAYERS.
//  Keeps a per-player shot budget and accepts shots and hit/miss results over valid/ready handshakes.
//  Reports the winner or a draw. Sits between input debouncers/cursor logic and the board/hit-check datapath.
// PARAMETERS
//  NUM_PLAYERS     2     players in rotation, 2..8
//  MAX_SHOTS       20    shot budget per player per game, >=1
//  HIT_REPEATS     1     1: a hit grants the same player another shot; 0: strict rotation
//  TIMEOUT_CYCLES  1000  idle cycles allowed in TURN (used only with TURN_TIMEOUT_EN), >=2
//  derived: PW = max(1,$clog2(NUM_PLAYERS)), SW = $clog2(MAX_SHOTS+1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  start_btn      in   1   debounced start, level
//  reset_btn      in   1   debounced reset/abort, level
//  setup_done     in   1   ship placement complete (1-cycle or level)
//  shot_valid     in   1   player offers a shot
//  shot_ready     out  1   high only in TURN
//  eval_valid     in   1   shot result available
//  eval_hit       in   1   1 = hit, qualified by eval_valid
//  eval_sunk_all  in   1   target fleet destroyed, qualified by eval_valid
//  eval_ready     out  1   high only in EVAL
//  current_state  out  5   one-hot {GAME_OVER,EVAL,TURN,SETUP,IDLE}
//  active_player  out  PW  player whose turn it is
//  shots_left     out  SW  remaining budget of active_player
//  winner         out  PW  winning player, valid when winner_valid
//  winner_valid   out  1   game ended by sink-all
//  draw           out  1   game ended with all budgets exhausted
//  restart_pulse  out  1   1-cycle pulse on IDLE->SETUP
//  timeout_pulse  out  1   1-cycle pulse on turn forfeit (0 without macro)
// BEHAVIOUR
//  reset: state=IDLE, active_player=0, all budgets=MAX_SHOTS, winner=0.
//   winner_valid, draw, restart_pulse and timeout_pulse all 0.
//  IDLE: start_btn|reset_btn -> SETUP next cycle.
//   In the same edge: restart_pulse=1 for 1 cycle, budgets reload to MAX_SHOTS, active_player=0,
//   winner_valid and draw cleared.
//  SETUP: setup_done -> TURN; otherwise hold.
//  TURN: shot accepted when shot_valid&shot_ready; active budget decrements; -> EVAL. Latency 1 cycle.
//  EVAL: wait for eval_valid (shot_valid ignored). On eval_valid, priority:
//   1) eval_sunk_all: -> GAME_OVER, winner=active_player, winner_valid=1
//   2) eval_hit & HIT_REPEATS & budget>0: stay with same player -> TURN
//   3) else advance to next player (wrap NUM_PLAYERS-1 -> 0), skipping players with budget 0 -> TURN
//   4) no player has budget left: -> GAME_OVER, draw=1
//  GAME_OVER: outputs hold; start_btn|reset_btn -> IDLE. No restart_pulse here.
//  reset_btn in SETUP/TURN/EVAL: abort to IDLE next cycle.
//   Any in-flight shot or result is discarded; budgets are not decremented further.
//  Simultaneous start_btn and reset_btn: treated as one press.
//  Held buttons: IDLE->SETUP fires once; the button is not re-sampled until IDLE is re-entered.
//  Illegal (non one-hot) state -> IDLE.
//  Budget arithmetic is saturating at 0; the counter never underflows.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined:
//   - A per-turn counter runs in TURN and clears on entering TURN.
//   - After TIMEOUT_CYCLES cycles without a handshake the turn is forfeit:
//     budget decrements, timeout_pulse=1 for 1 cycle, rotation follows rule 3 (or 4).
//   - A handshake in the final cycle wins over the timeout.
//  TURN_TIMEOUT_EN undefined: TURN waits indefinitely; timeout_pulse tied 0; no counter logic.
// STRUCTURE
//  battleship_pkg: state one-hot localparams (ST_IDLE..ST_GAME_OVER), state index constants,
//   next_player() rotation function.
//  Sub-module battleship_turn_timer (load/enable/expire) is instantiated only under TURN_TIMEOUT_EN.
//  Budgets: NUM_PLAYERS x SW register array inside this module.
// TESTING
//  1) NP=2, MS=3, HIT_REPEATS=0, all misses:
//     turns alternate 0,1,0,1,0,1 -> draw=1 after 6th result, winner_valid=0.
//  2) Player 0 hits with HIT_REPEATS=1:
//     active_player stays 0 and shots_left goes 20->19->18; a miss then passes to player 1.
//  3) eval_sunk_all on player 1's first shot -> GAME_OVER, winner=1, winner_valid=1;
//     start_btn -> IDLE, then start -> restart_pulse exactly 1 cycle, budgets=20.
//  4) reset_btn asserted while waiting in EVAL with eval_valid same cycle:
//     -> IDLE, no winner, no budget change.
//  5) NP=3, player 1 budget 0: miss by player 0 -> active_player=2 (skip).
//  6) TURN_TIMEOUT_EN, TIMEOUT_CYCLES=8, no shot_valid:
//     timeout_pulse at 8th cycle, shots_left-1, next player; handshake on 8th cycle -> EVAL, no pulse.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types for the battleship game controller: one-hot state encoding,
// state bit indices and the round-robin player rotation helper.
package battleship_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_SETUP     = 5'b00010,
    ST_TURN      = 5'b00100,
    ST_EVAL      = 5'b01000,
    ST_GAME_OVER = 5'b10000
  } state_t;

  localparam int unsigned IDX_IDLE      = 0;
  localparam int unsigned IDX_SETUP     = 1;
  localparam int unsigned IDX_TURN      = 2;
  localparam int unsigned IDX_EVAL      = 3;
  localparam int unsigned IDX_GAME_OVER = 4;

  localparam int unsigned MAX_PLAYERS = 8;

  // First player after cur (wrapping) whose avail bit is set; cur itself is
  // the last candidate. Callers check |avail before trusting the result.
  function automatic int unsigned next_player(input int unsigned cur,
                                              input int unsigned num_players,
                                              input logic [MAX_PLAYERS-1:0] avail);
    int unsigned idx;
    logic        found;
    next_player = cur;
    found       = 1'b0;
    for (int unsigned k = 1; k <= MAX_PLAYERS; k++) begin
      if (k <= num_players) begin
        idx = cur + k;
        if (idx >= num_players) idx = idx - num_players;
        if (!found && avail[idx[2:0]]) begin
          next_player = idx;
          found       = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/battleship_turn_timer.sv
// Per-turn idle counter: load clears, enable counts, expire flags the final
// cycle of the allowed window. Used only when TURN_TIMEOUT_EN is defined.
module battleship_turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/battleship_turn_ctrl.sv
// N-player battleship game controller: setup, round-robin turns with shot budgets,
// hit/miss evaluation and winner/draw reporting. Optional turn timeout: TURN_TIMEOUT_EN.
module battleship_turn_ctrl
  import battleship_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS    = 2,
  parameter  int unsigned MAX_SHOTS      = 20,
  parameter  int unsigned HIT_REPEATS    = 1,
  parameter  int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned SW = $clog2(MAX_SHOTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_btn,
  input  logic          reset_btn,
  input  logic          setup_done,
  input  logic          shot_valid,
  output logic          shot_ready,
  input  logic          eval_valid,
  input  logic          eval_hit,
  input  logic          eval_sunk_all,
  output logic          eval_ready,
  output logic [4:0]    current_state,
  output logic [PW-1:0] active_player,
  output logic [SW-1:0] shots_left,
  output logic [PW-1:0] winner,
  output logic          winner_valid,
  output logic          draw,
  output logic          restart_pulse,
  output logic          timeout_pulse
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > MAX_PLAYERS || MAX_SHOTS < 1 || TIMEOUT_CYCLES < 2)
  begin : g_param_check
    $error("battleship_turn_ctrl: parameter out of range");
  end

  state_t                 state, state_nxt;
  logic [PW-1:0]          player, player_nxt, rot_player;
  logic [SW-1:0]          budget [NUM_PLAYERS];
  logic [SW-1:0]          budget_cur, budget_dec;
  logic [MAX_PLAYERS-1:0] avail;
  logic                   any_avail;
  logic                   start_prev, reset_prev, reset_edge, press;
  logic                   handshake, forfeit, dec, expire;
  logic                   restart, win_set, draw_set;

  // Buttons act on their rising edge, so a held button fires exactly once.
  assign reset_edge = reset_btn & ~reset_prev;
  assign press      = (start_btn & ~start_prev) | reset_edge;

  assign handshake  = (state == ST_TURN) & shot_valid & ~reset_edge;
  assign forfeit    = (state == ST_TURN) & ~shot_valid & expire & ~reset_edge;
  assign dec        = handshake | forfeit;

  assign budget_cur = budget[player];
  assign budget_dec = (budget_cur == '0) ? '0 : budget_cur - 1'b1;

`ifdef TURN_TIMEOUT_EN
  logic timer_load, timer_enable;

  assign timer_enable = (state == ST_TURN);
  assign timer_load   = (state != ST_TURN) | dec | reset_edge;

  battleship_turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .enable (timer_enable),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Availability reflects the decrement landing on this same edge.
  always_comb begin
    avail = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (player == PW'(p) && dec) avail[p[2:0]] = (budget_dec != '0);
      else                         avail[p[2:0]] = (budget[p[PW-1:0]] != '0);
    end
  end

  assign any_avail  = |avail;
  assign rot_player = PW'(next_player(32'(player), NUM_PLAYERS, avail));

  always_comb begin
    state_nxt  = state;
    player_nxt = player;
    restart    = 1'b0;
    win_set    = 1'b0;
    draw_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press) begin
          state_nxt  = ST_SETUP;
          player_nxt = '0;
          restart    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (reset_edge)      state_nxt = ST_IDLE;
        else if (setup_done) state_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (reset_edge) begin
          state_nxt = ST_IDLE;
        end else if (handshake) begin
          state_nxt = ST_EVAL;
        end else if (forfeit) begin
          if (any_avail) begin
            state_nxt  = ST_TURN;
            player_nxt = rot_player;
          end else begin
            state_nxt = ST_GAME_OVER;
            draw_set  = 1'b1;
          end
        end
      end
      ST_EVAL: begin
        if (reset_edge) begin
          state_nxt = ST_IDLE;
        end else if (eval_valid) begin
          if (eval_sunk_all) begin
            state_nxt = ST_GAME_OVER;
            win_set   = 1'b1;
          end else if (eval_hit && HIT_REPEATS != 0 && budget_cur != '0) begin
            state_nxt = ST_TURN;
          end else if (any_avail) begin
            state_nxt  = ST_TURN;
            player_nxt = rot_player;
          end else begin
            state_nxt = ST_GAME_OVER;
            draw_set  = 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (press) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      player        <= '0;
      winner        <= '0;
      winner_valid  <= 1'b0;
      draw          <= 1'b0;
      restart_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      start_prev    <= 1'b0;
      reset_prev    <= 1'b0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) budget[p[PW-1:0]] <= SW'(MAX_SHOTS);
    end else begin
      state         <= state_nxt;
      player        <= player_nxt;
      restart_pulse <= restart;
      timeout_pulse <= forfeit;
      start_prev    <= start_btn;
      reset_prev    <= reset_btn;
      if (restart) begin
        winner_valid <= 1'b0;
        draw         <= 1'b0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) budget[p[PW-1:0]] <= SW'(MAX_SHOTS);
      end
      if (dec)      budget[player] <= budget_dec;
      if (win_set) begin
        winner       <= player;
        winner_valid <= 1'b1;
      end
      if (draw_set) draw <= 1'b1;
    end
  end

  assign current_state = state;
  assign active_player = player;
  assign shots_left    = budget[player];
  assign shot_ready    = (state == ST_TURN);
  assign eval_ready    = (state == ST_EVAL);

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Scoreboard bench: DUT 0 (3 players, hit repeats) and DUT 1 (2 players, strict rotation).
module tb_battleship_turn_ctrl;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_SETUP = 5'b00010;
  localparam logic [4:0] S_TURN  = 5'b00100;
  localparam logic [4:0] S_EVAL  = 5'b01000;
  localparam logic [4:0] S_GO    = 5'b10000;

  typedef struct packed {
    logic [4:0] st;
    logic [2:0] pl;
    logic [1:0] sl;
    logic [2:0] win;
    logic       wv;
    logic       dr;
    logic       rp;
    logic       tp;
    logic       sr;
    logic       er;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic start_btn [2];
  logic reset_btn [2];
  logic setup_done [2];
  logic shot_valid [2];
  logic eval_valid [2];
  logic eval_hit [2];
  logic eval_sunk_all [2];

  obs_t obs [2];
  obs_t exp_q [2][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned NP  = (g == 0) ? 3 : 2;
    localparam int unsigned HR  = (g == 0) ? 1 : 0;
    localparam int unsigned PWG = (g == 0) ? 2 : 1;
    logic [4:0]     st;
    logic [PWG-1:0] ap, win;
    logic [1:0]     sl;
    logic           wv, dr, rp, tp, sr, er;

    battleship_turn_ctrl #(
      .NUM_PLAYERS   (NP),
      .MAX_SHOTS     (3),
      .HIT_REPEATS   (HR),
      .TIMEOUT_CYCLES(8)
    ) dut (
      .clk          (clk),
      .reset        (rst),
      .start_btn    (start_btn[g]),
      .reset_btn    (reset_btn[g]),
      .setup_done   (setup_done[g]),
      .shot_valid   (shot_valid[g]),
      .shot_ready   (sr),
      .eval_valid   (eval_valid[g]),
      .eval_hit     (eval_hit[g]),
      .eval_sunk_all(eval_sunk_all[g]),
      .eval_ready   (er),
      .current_state(st),
      .active_player(ap),
      .shots_left   (sl),
      .winner       (win),
      .winner_valid (wv),
      .draw         (dr),
      .restart_pulse(rp),
      .timeout_pulse(tp)
    );

    assign obs[g] = {st, 3'(ap), sl, 3'(win), wv, dr, rp, tp, sr, er};
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%b pl=%0d sl=%0d win=%0d wv=%b dr=%b rp=%b tp=%b sr=%b er=%b",
                     o.st, o.pl, o.sl, o.win, o.wv, o.dr, o.rp, o.tp, o.sr, o.er);
  endfunction

  function automatic void push(input int d, input logic [4:0] st, input int pl, input int sl,
                               input int win, input logic wv, input logic dr,
                               input logic rp, input logic tp);
    obs_t r;
    r.st  = st;
    r.pl  = 3'(pl);
    r.sl  = 2'(sl);
    r.win = 3'(win);
    r.wv  = wv;
    r.dr  = dr;
    r.rp  = rp;
    r.tp  = tp;
    r.sr  = (st == S_TURN);
    r.er  = (st == S_EVAL);
    exp_q[d].push_back(r);
  endfunction

  // Monitor: an observable event is a state change or a pulse output.
  initial begin
    logic [4:0] prev_st [2];
    int         ev_n [2];
    obs_t       e;
    for (int d = 0; d < 2; d++) begin
      prev_st[d] = '0;
      ev_n[d]    = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          prev_st[d] = '0;
        end else if (obs[d].st != prev_st[d] || obs[d].rp || obs[d].tp) begin
          prev_st[d] = obs[d].st;
          n_checks++;
          if (exp_q[d].size() == 0) begin
            n_fail++;
            $display("FAIL dut%0d event%0d unexpected: got %s", d, ev_n[d], fmt(obs[d]));
          end else begin
            e = exp_q[d].pop_front();
            if (obs[d] !== e) begin
              n_fail++;
              $display("FAIL dut%0d event%0d: got %s expected %s", d, ev_n[d], fmt(obs[d]), fmt(e));
            end
          end
          ev_n[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_btn(input int d, input logic s, input logic r);
    start_btn[d] = s;
    reset_btn[d] = r;
    tick();
    start_btn[d] = 1'b0;
    reset_btn[d] = 1'b0;
    tick();
  endtask

  task automatic pulse_setup(input int d);
    setup_done[d] = 1'b1;
    tick();
    setup_done[d] = 1'b0;
  endtask

  task automatic pulse_shot(input int d);
    shot_valid[d] = 1'b1;
    tick();
    shot_valid[d] = 1'b0;
  endtask

  task automatic pulse_eval(input int d, input logic hit, input logic sunk);
    eval_valid[d]    = 1'b1;
    eval_hit[d]      = hit;
    eval_sunk_all[d] = sunk;
    tick();
    eval_valid[d]    = 1'b0;
    eval_hit[d]      = 1'b0;
    eval_sunk_all[d] = 1'b0;
  endtask

  task automatic run_a();
    push(0, S_SETUP, 0, 3, 0, 0, 0, 1, 0); pulse_btn(0, 1, 0);
    push(0, S_TURN,  0, 3, 0, 0, 0, 0, 0); pulse_setup(0);
    push(0, S_EVAL,  0, 2, 0, 0, 0, 0, 0); pulse_shot(0);
    pulse_shot(0);
    tick();
    push(0, S_TURN,  0, 2, 0, 0, 0, 0, 0); pulse_eval(0, 1, 0);
    push(0, S_EVAL,  0, 1, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  1, 3, 0, 0, 0, 0, 0); pulse_eval(0, 0, 0);
    push(0, S_EVAL,  1, 2, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  1, 2, 0, 0, 0, 0, 0); pulse_eval(0, 1, 0);
    push(0, S_EVAL,  1, 1, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  1, 1, 0, 0, 0, 0, 0); pulse_eval(0, 1, 0);
    push(0, S_EVAL,  1, 0, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  2, 3, 0, 0, 0, 0, 0); pulse_eval(0, 1, 0);
    push(0, S_EVAL,  2, 2, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  0, 1, 0, 0, 0, 0, 0); pulse_eval(0, 0, 0);
    push(0, S_EVAL,  0, 0, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_TURN,  2, 2, 0, 0, 0, 0, 0); pulse_eval(0, 0, 0);
    push(0, S_EVAL,  2, 1, 0, 0, 0, 0, 0); pulse_shot(0);
    push(0, S_GO,    2, 1, 2, 1, 0, 0, 0); pulse_eval(0, 1, 1);
    repeat (3) tick();
    push(0, S_IDLE,  2, 1, 2, 1, 0, 0, 0); pulse_btn(0, 1, 0);
    push(0, S_SETUP, 0, 3, 2, 0, 0, 1, 0); pulse_btn(0, 1, 0);
    push(0, S_TURN,  0, 3, 2, 0, 0, 0, 0); pulse_setup(0);
    push(0, S_EVAL,  0, 2, 2, 0, 0, 0, 0); pulse_shot(0);
    repeat (2) tick();
    push(0, S_IDLE,  0, 2, 2, 0, 0, 0, 0);
    reset_btn[0] = 1'b1; eval_valid[0] = 1'b1; eval_hit[0] = 1'b1; eval_sunk_all[0] = 1'b1;
    tick();
    reset_btn[0] = 1'b0; eval_valid[0] = 1'b0; eval_hit[0] = 1'b0; eval_sunk_all[0] = 1'b0;
    tick();
    push(0, S_SETUP, 0, 3, 2, 0, 0, 1, 0); pulse_btn(0, 1, 0);
    push(0, S_TURN,  0, 3, 2, 0, 0, 0, 0); pulse_setup(0);
    push(0, S_IDLE,  0, 3, 2, 0, 0, 0, 0);
    reset_btn[0] = 1'b1; shot_valid[0] = 1'b1;
    tick();
    reset_btn[0] = 1'b0; shot_valid[0] = 1'b0;
    tick();
    push(0, S_SETUP, 0, 3, 2, 0, 0, 1, 0); pulse_btn(0, 1, 0);
    push(0, S_TURN,  0, 3, 2, 0, 0, 0, 0); pulse_setup(0);
`ifdef TURN_TIMEOUT_EN
    push(0, S_TURN,  1, 3, 2, 0, 0, 0, 1); repeat (8) tick();
    push(0, S_EVAL,  1, 2, 2, 0, 0, 0, 0); repeat (7) tick(); pulse_shot(0);
    push(0, S_TURN,  2, 3, 2, 0, 0, 0, 0); pulse_eval(0, 0, 0);
`else
    repeat (12) tick();
    push(0, S_EVAL,  0, 2, 2, 0, 0, 0, 0); pulse_shot(0);
`endif
  endtask

  task automatic run_b();
    int ev_pl [6] = '{0, 1, 0, 1, 0, 1};
    int ev_sl [6] = '{2, 2, 1, 1, 0, 0};
    int nx_pl [6] = '{1, 0, 1, 0, 1, 1};
    int nx_sl [6] = '{3, 2, 2, 1, 1, 0};
    push(1, S_SETUP, 0, 3, 0, 0, 0, 1, 0); pulse_btn(1, 1, 0);
    push(1, S_TURN,  0, 3, 0, 0, 0, 0, 0); pulse_setup(1);
    for (int i = 0; i < 6; i++) begin
      push(1, S_EVAL, ev_pl[i], ev_sl[i], 0, 0, 0, 0, 0);
      pulse_shot(1);
      tick();
      if (i < 5) push(1, S_TURN, nx_pl[i], nx_sl[i], 0, 0, 0, 0, 0);
      else       push(1, S_GO,   nx_pl[i], nx_sl[i], 0, 0, 1, 0, 0);
      pulse_eval(1, 0, 0);
    end
    repeat (3) tick();
    push(1, S_IDLE,  1, 0, 0, 0, 1, 0, 0); pulse_btn(1, 0, 1);
    push(1, S_SETUP, 0, 3, 0, 0, 0, 1, 0); pulse_btn(1, 1, 1);
    push(1, S_IDLE,  0, 3, 0, 0, 0, 0, 0);
    reset_btn[1] = 1'b1;
    repeat (4) tick();
    reset_btn[1] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_btn[d] = 1'b0; reset_btn[d] = 1'b0; setup_done[d] = 1'b0; shot_valid[d] = 1'b0;
      eval_valid[d] = 1'b0; eval_hit[d] = 1'b0; eval_sunk_all[d] = 1'b0;
    end
    push(0, S_IDLE, 0, 3, 0, 0, 0, 0, 0);
    push(1, S_IDLE, 0, 3, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fork
      run_a();
      run_b();
    join
    for (int i = 0; i < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      while (exp_q[d].size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d missing_event: got none expected %s", d, fmt(exp_q[d].pop_front()));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
